// File: rtl/alu_wb_router_pkg.sv
// alu_wb_router shared package
// select codes and FSM encodings
package alu_wb_router_pkg;

  localparam logic [3:0] WB_NOP  = 4'b0000;
  localparam logic [3:0] WB_REG  = 4'b0001;
  localparam logic [3:0] WB_PC   = 4'b0010;
  localparam logic [3:0] WB_SP   = 4'b0011;
  localparam logic [3:0] WB_MEM  = 4'b0100;
  localparam logic [3:0] WB_PUSH = 4'b0101;
  localparam logic [3:0] WB_POP  = 4'b0110;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_SPUPD = 2'd3;

  function automatic logic wb_is_mem(
    input logic [3:0] sel
  );
    return (sel == WB_MEM) || (sel == WB_PUSH);
  endfunction

endpackage

// File: rtl/alu_wb_router_if.sv
// alu_wb_router bus interface
// control/ALU side is master, router is slave
interface alu_wb_router_if #(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3
);
  logic                 wb_valid;
  logic                 wb_ready;
  logic [3:0]           alu_out_sel;
  logic [DATA_W-1:0]    alu_result;
  logic [3:0]           alu_flags;
  logic                 flag_we;
  logic [REG_IDX_W-1:0] dr_idx;
  logic [DATA_W-1:0]    mem_addr_in;
  logic [DATA_W-1:0]    sp;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic                 pc_we;
  logic [DATA_W-1:0]    pc_wdata;
  logic                 sp_we;
  logic [DATA_W-1:0]    sp_wdata;
  logic                 flags_we;
  logic [3:0]           flags_wdata;
  logic                 mem_wr_req;
  logic [DATA_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_ack;
  logic                 wb_done;
  logic                 wb_err;

  modport master (
    output wb_valid, alu_out_sel, alu_result,
    output alu_flags, flag_we, dr_idx,
    output mem_addr_in, sp, mem_ack,
    input  wb_ready, rf_we, rf_waddr, rf_wdata,
    input  pc_we, pc_wdata, sp_we, sp_wdata,
    input  flags_we, flags_wdata,
    input  mem_wr_req, mem_addr, mem_wdata,
    input  wb_done, wb_err
  );

  modport slave (
    input  wb_valid, alu_out_sel, alu_result,
    input  alu_flags, flag_we, dr_idx,
    input  mem_addr_in, sp, mem_ack,
    output wb_ready, rf_we, rf_waddr, rf_wdata,
    output pc_we, pc_wdata, sp_we, sp_wdata,
    output flags_we, flags_wdata,
    output mem_wr_req, mem_addr, mem_wdata,
    output wb_done, wb_err
  );
endinterface

// File: rtl/alu_wb_router_wb_mem_timer.sv
// wb_mem_timer: loadable down-counter
// expire_o flags the last allowed wait cycle
module wb_mem_timer #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);
  localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // reload on accept, count down while waiting
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(MAX);
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // MAX=0 loads zero, so this never fires
  assign expire_o = (cnt_q == CW'(1));
endmodule

// File: rtl/alu_wb_router.sv
// alu_wb_router: routes ALU results to
// RF/PC/SP/flags/memory with push/pop
module alu_wb_router
  import alu_wb_router_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_IDX_W   = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  alu_wb_router_if.slave bus
);
  logic [1:0]           state_q, state_d;
  logic [3:0]           sel_q;
  logic [DATA_W-1:0]    res_q;
  logic [3:0]           flg_q;
  logic                 fwe_q;
  logic [REG_IDX_W-1:0] dr_q;
  logic [DATA_W-1:0]    addr_q;
  logic [DATA_W-1:0]    sp_q;

  logic accept, in_mem, ack, expire, tmo;

  assign accept = bus.wb_valid
                & (state_q == ST_IDLE);
  assign in_mem = (state_q == ST_MEM);
  assign ack    = in_mem & bus.mem_ack;
  assign tmo    = in_mem & ~bus.mem_ack
                & expire;

  wb_mem_timer #(
    .MAX (MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .dec_i    (in_mem & ~bus.mem_ack),
    .expire_o (expire)
  );

  // latch the request on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      res_q  <= '0;
      flg_q  <= '0;
      fwe_q  <= 1'b0;
      dr_q   <= '0;
      addr_q <= '0;
      sp_q   <= '0;
    end else if (accept) begin
      sel_q  <= bus.alu_out_sel;
      res_q  <= bus.alu_result;
      flg_q  <= bus.alu_flags;
      fwe_q  <= bus.flag_we;
      dr_q   <= bus.dr_idx;
      sp_q   <= bus.sp;
      addr_q <= (bus.alu_out_sel == WB_PUSH)
              ? bus.sp - DATA_W'(1)
              : bus.mem_addr_in;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_IDLE):
        if (accept)
          state_d = wb_is_mem(bus.alu_out_sel)
                  ? ST_MEM : ST_EXEC;
      (state_q == ST_MEM):
        if (ack)
          state_d = (sel_q == WB_PUSH)
                  ? ST_SPUPD : ST_IDLE;
        else if (tmo)
          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // output decode
  always_comb begin
    bus.wb_ready    = (state_q == ST_IDLE);
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.pc_we       = 1'b0;
    bus.pc_wdata    = '0;
    bus.sp_we       = 1'b0;
    bus.sp_wdata    = '0;
    bus.flags_we    = 1'b0;
    bus.flags_wdata = '0;
    bus.mem_wr_req  = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.wb_done     = 1'b0;
    bus.wb_err      = 1'b0;
    unique case (1'b1)
      (state_q == ST_EXEC): begin
        bus.wb_done = 1'b1;
        case (sel_q)
          WB_NOP: ;
          WB_REG: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = dr_q;
            bus.rf_wdata = res_q;
          end
          WB_PC: begin
            bus.pc_we    = 1'b1;
            bus.pc_wdata = res_q;
          end
          WB_SP: begin
            bus.sp_we    = 1'b1;
            bus.sp_wdata = res_q;
          end
          WB_POP: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = dr_q;
            bus.rf_wdata = res_q;
            bus.sp_we    = 1'b1;
            bus.sp_wdata = sp_q + DATA_W'(1);
          end
          default: bus.wb_err = 1'b1;
        endcase
        bus.flags_we = fwe_q & ~bus.wb_err;
      end
      (state_q == ST_MEM): begin
        bus.mem_wr_req = 1'b1;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = res_q;
        if (ack && sel_q == WB_MEM) begin
          bus.wb_done  = 1'b1;
          bus.flags_we = fwe_q;
        end else if (tmo) begin
          bus.wb_done  = 1'b1;
          bus.wb_err   = 1'b1;
        end
      end
      (state_q == ST_SPUPD): begin
        bus.sp_we    = 1'b1;
        bus.sp_wdata = addr_q;
        bus.wb_done  = 1'b1;
        bus.flags_we = fwe_q;
      end
      default: ;
    endcase
    if (bus.flags_we)
      bus.flags_wdata = flg_q;
  end
endmodule

// File: tb/tb_alu_wb_router.sv
// tb_alu_wb_router: random + directed
// checks against a transaction-level model
module tb_alu_wb_router;
  localparam int TMO = 4;

  typedef struct {
    bit        rf_we;
    bit [2:0]  rf_waddr;
    bit [15:0] rf_wdata;
    bit        pc_we;
    bit [15:0] pc;
    bit        sp_we;
    bit [15:0] spw;
    bit        fl_we;
    bit [3:0]  fl;
    bit        req;
    bit [15:0] ma;
    bit [15:0] md;
    bit        done;
    bit        err;
    bit        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_wb_router_if #(
    .DATA_W    (16),
    .REG_IDX_W (3)
  ) bus ();

  alu_wb_router #(
    .DATA_W      (16),
    .REG_IDX_W   (3),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e = '{default: 0};
    e.rdy = 1'b1;
    return e;
  endfunction

  task automatic check_cyc(
    input string t,
    input exp_t  e
  );
    chk({t, ".rf_we"}, 16'(bus.rf_we), 16'(e.rf_we));
    if (e.rf_we) begin
      chk({t, ".rf_waddr"}, 16'(bus.rf_waddr),
          16'(e.rf_waddr));
      chk({t, ".rf_wdata"}, bus.rf_wdata, e.rf_wdata);
    end
    chk({t, ".pc_we"}, 16'(bus.pc_we), 16'(e.pc_we));
    if (e.pc_we)
      chk({t, ".pc_wdata"}, bus.pc_wdata, e.pc);
    chk({t, ".sp_we"}, 16'(bus.sp_we), 16'(e.sp_we));
    if (e.sp_we)
      chk({t, ".sp_wdata"}, bus.sp_wdata, e.spw);
    chk({t, ".flags_we"}, 16'(bus.flags_we),
        16'(e.fl_we));
    if (e.fl_we)
      chk({t, ".flags_wdata"}, 16'(bus.flags_wdata),
          16'(e.fl));
    chk({t, ".req"}, 16'(bus.mem_wr_req), 16'(e.req));
    if (e.req) begin
      chk({t, ".mem_addr"}, bus.mem_addr, e.ma);
      chk({t, ".mem_wdata"}, bus.mem_wdata, e.md);
    end
    chk({t, ".done"}, 16'(bus.wb_done), 16'(e.done));
    chk({t, ".err"}, 16'(bus.wb_err), 16'(e.err));
    chk({t, ".ready"}, 16'(bus.wb_ready), 16'(e.rdy));
  endtask

  task automatic scramble();
    bus.alu_out_sel = 4'($urandom);
    bus.alu_result  = 16'($urandom);
    bus.alu_flags   = 4'($urandom);
    bus.flag_we     = 1'($urandom);
    bus.dr_idx      = 3'($urandom);
    bus.mem_addr_in = 16'($urandom);
    bus.sp          = 16'($urandom);
  endtask

  // enters and leaves at negedge+1
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.wb_valid = 1'b0;
      bus.mem_ack  = 1'($urandom);
      #1 check_cyc("idle", idle_exp());
    end
  endtask

  // one request; dly = cycles of MEM before ack
  task automatic run_req(
    input string       t,
    input logic [3:0]  sel,
    input logic [15:0] res,
    input logic [3:0]  fl,
    input logic        fwe,
    input logic [2:0]  dr,
    input logic [15:0] addr,
    input logic [15:0] sp,
    input int          dly
  );
    exp_t q[$];
    bit   ackq[$];
    exp_t e;
    bit   is_mem = (sel == 4'd4) || (sel == 4'd5);
    bit   illegal = (sel > 4'd6);
    logic [15:0] spm1 = sp - 16'd1;
    logic [15:0] spp1 = sp + 16'd1;
    if (!is_mem) begin
      e = '{default: 0};
      e.rf_we    = (sel == 4'd1) || (sel == 4'd6);
      e.rf_waddr = dr;
      e.rf_wdata = res;
      e.pc_we    = (sel == 4'd2);
      e.pc       = res;
      e.sp_we    = (sel == 4'd3) || (sel == 4'd6);
      e.spw      = (sel == 4'd3) ? res : spp1;
      e.fl_we    = fwe && !illegal;
      e.fl       = fl;
      e.done     = 1'b1;
      e.err      = illegal;
      q.push_back(e);
      ackq.push_back(1'($urandom));
    end else begin
      int n = (dly < TMO) ? dly + 1 : TMO;
      bit acked = (dly < TMO);
      for (int k = 1; k <= n; k++) begin
        e = '{default: 0};
        e.req = 1'b1;
        e.ma  = (sel == 4'd4) ? addr : spm1;
        e.md  = res;
        if (k == n) begin
          if (acked) begin
            e.done  = (sel == 4'd4);
            e.fl_we = (sel == 4'd4) && fwe;
            e.fl    = fl;
          end else begin
            e.done = 1'b1;
            e.err  = 1'b1;
          end
        end
        q.push_back(e);
        ackq.push_back(acked && k == n);
      end
      if (acked && sel == 4'd5) begin
        e = '{default: 0};
        e.sp_we = 1'b1;
        e.spw   = spm1;
        e.done  = 1'b1;
        e.fl_we = fwe;
        e.fl    = fl;
        q.push_back(e);
        ackq.push_back(1'($urandom));
      end
    end
    bus.wb_valid    = 1'b1;
    bus.alu_out_sel = sel;
    bus.alu_result  = res;
    bus.alu_flags   = fl;
    bus.flag_we     = fwe;
    bus.dr_idx      = dr;
    bus.mem_addr_in = addr;
    bus.sp          = sp;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    scramble();
    foreach (q[i]) begin
      bus.mem_ack = ackq[i];
      #1 check_cyc(t, q[i]);
      @(negedge clk);
    end
    bus.mem_ack = 1'($urandom);
    #1 check_cyc({t, ".after"}, idle_exp());
  endtask

  task automatic reset_mid_mem();
    bus.wb_valid    = 1'b1;
    bus.alu_out_sel = 4'd5;
    bus.alu_result  = 16'h5555;
    bus.flag_we     = 1'b1;
    bus.sp          = 16'h0200;
    bus.mem_ack     = 1'b0;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1 chk("rst.req_before", 16'(bus.mem_wr_req), 16'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_cyc("rst.async", idle_exp());
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1 check_cyc("rst.hold", idle_exp());
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst_n = 1'b1;
    #1 check_cyc("rst.release", idle_exp());
    idle_cycles(3);
  endtask

  initial begin
    logic [3:0]  sel;
    logic [15:0] sp;
    bus.wb_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    scramble();
    #3 check_cyc("reset", idle_exp());
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_cyc("post_reset", idle_exp());

    run_req("t1_reg", 4'd1, 16'h1234, 4'h0, 1'b0,
            3'd5, 16'h0, 16'h0, 0);
    run_req("t2_push", 4'd5, 16'hBEEF, 4'h3, 1'b1,
            3'd0, 16'h0, 16'h0100, 2);
    run_req("t3_popwrap", 4'd6, 16'h00AA, 4'h0, 1'b0,
            3'd2, 16'h0, 16'hFFFF, 0);
    run_req("t4_timeout", 4'd4, 16'h7777, 4'hF, 1'b1,
            3'd0, 16'h1000, 16'h0, 99);
    reset_mid_mem();
    run_req("t6_illegal", 4'hF, 16'h4321, 4'hA, 1'b1,
            3'd7, 16'h0, 16'h0, 0);
    run_req("pushwrap", 4'd5, 16'h0101, 4'h1, 1'b0,
            3'd0, 16'h0, 16'h0000, 0);
    run_req("ack_at_limit", 4'd4, 16'h2222, 4'h6, 1'b1,
            3'd0, 16'hABCD, 16'h0, TMO - 1);
    run_req("push_tmo", 4'd5, 16'h3333, 4'h6, 1'b1,
            3'd0, 16'h0, 16'h0040, TMO + 1);

    for (int i = 0; i < 300; i++) begin
      sel = 4'($urandom);
      if ($urandom_range(0, 3) != 0)
        sel = 4'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       sp = 16'h0000;
        1:       sp = 16'hFFFF;
        default: sp = 16'($urandom);
      endcase
      run_req("rnd", sel, 16'($urandom), 4'($urandom),
              1'($urandom), 3'($urandom),
              16'($urandom), sp,
              int'($urandom_range(0, TMO + 1)));
      if ($urandom_range(0, 3) == 0)
        idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
